// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the next-PC redirect controller
package pc_ctrl_pkg;
  typedef enum logic [1:0] {RUN, HOLD, HALT} pc_ctrl_state_t;
  localparam int CNT_W = 16;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + 1'b1;
  end
  assign count = count_q;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: EX branch result to fetch redirect, wrong-path squash, halt and stats
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W    = 9,
  parameter logic [PC_W-1:0] TRAP_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_ctrl,
  input  logic             ex_pcsel,
  input  logic [31:0]      ex_brpc,
  input  logic             halt_req,
  input  logic             pc_ready,
  output logic             pc_valid,
  output logic [PC_W-1:0]  pc_next,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misalign_err,
  output logic             halted,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);
  pc_ctrl_state_t  state_q, state_d;
  logic [PC_W-1:0] hold_q, hold_d;
  logic [PC_W-1:0] tgt, seq_pc;
  logic            redirect, mis, flush, br_inc, tk_inc;
  logic            unused_brpc_hi;

  assign unused_brpc_hi = ^ex_brpc[31:PC_W];

  always_comb begin
    mis = ex_brpc[1:0] != 2'b00;
    tgt = mis ? TRAP_PC : ex_brpc[PC_W-1:0];
    seq_pc = if_pc + PC_W'(PC_STEP);
    redirect = state_q == RUN && ex_valid && ex_pcsel;
    state_d = state_q;
    hold_d = hold_q;
    pc_valid = 1'b0;
    pc_next = seq_pc;
    flush = 1'b0;
    br_inc = 1'b0;
    tk_inc = 1'b0;
    case (state_q)
      RUN: begin
        br_inc = ex_valid && ex_ctrl;
        if (redirect) begin
          pc_valid = 1'b1;
          pc_next = tgt;
          flush = 1'b1;
          tk_inc = pc_ready;
          if (!pc_ready) begin
            state_d = HOLD;
            hold_d = tgt;
          end
        end else begin
          pc_valid = !stall && !halt_req;
          if (halt_req) state_d = HALT;
        end
      end
      HOLD: begin
        pc_valid = 1'b1;
        pc_next = hold_q;
        flush = 1'b1;
        tk_inc = pc_ready;
        if (pc_ready) state_d = halt_req ? HALT : RUN;
      end
      default: ;
    endcase
    // reset forces a quiet, fully-squashed pipeline front end
    pc_valid = pc_valid && !reset;
    flush_ifid = flush || reset;
    flush_idex = flush || reset;
    misalign_err = redirect && mis && !reset;
    halted = state_q == HALT && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (.clk(clk), .reset(reset), .inc(br_inc), .count(br_cnt));
  sat_counter #(.W(CNT_W)) u_tk_cnt (.clk(clk), .reset(reset), .inc(tk_inc), .count(tk_cnt));
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: table-driven scoreboard bench for the redirect controller
module tb_pc_redirect_ctrl;
  typedef struct packed {
    logic        pv;
    logic [8:0]  pc;
    logic        fi, fe, me, h;
    logic [15:0] br, tk;
  } out_t;
  typedef struct packed {
    logic        rst, v, c, p;
    logic [31:0] brpc;
    logic [8:0]  ifpc;
    logic        stall, halt, ready;
    out_t        o;
    logic        pcx;
  } row_t;
  typedef struct {
    string name;
    int    idx;
    out_t  e;
    out_t  m;
  } sb_t;

  logic        clk = 0, reset = 1;
  logic [8:0]  if_pc = '0;
  logic        stall = 0, ex_valid = 0, ex_ctrl = 0, ex_pcsel = 0, halt_req = 0, pc_ready = 0;
  logic [31:0] ex_brpc = '0;
  logic        pc_valid, flush_ifid, flush_idex, misalign_err, halted;
  logic [8:0]  pc_next;
  logic [15:0] br_cnt, tk_cnt;
  out_t        obs;
  sb_t         sb_q[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.PC_W(9), .TRAP_PC(9'h000)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .stall(stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_pcsel(ex_pcsel), .ex_brpc(ex_brpc), .halt_req(halt_req),
    .pc_ready(pc_ready), .pc_valid(pc_valid), .pc_next(pc_next), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .misalign_err(misalign_err), .halted(halted),
    .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  assign obs = {pc_valid, pc_next, flush_ifid, flush_idex, misalign_err, halted, br_cnt, tk_cnt};

  function automatic row_t rw(input logic rst, v, c, p, input logic [31:0] b, input logic [8:0] ip,
                              input logic st, hl, rd, input logic pv, input logic [8:0] pc,
                              input logic fl, me, h, input logic [15:0] br, tk, input logic pcx);
    row_t r;
    r = {rst, v, c, p, b, ip, st, hl, rd, pv, pc, fl, fl, me, h, br, tk, pcx};
    return r;
  endfunction

  task automatic apply(input row_t r, input string name, input int idx);
    sb_t s;
    reset = r.rst; ex_valid = r.v; ex_ctrl = r.c; ex_pcsel = r.p; ex_brpc = r.brpc;
    if_pc = r.ifpc; stall = r.stall; halt_req = r.halt; pc_ready = r.ready;
    s.name = name; s.idx = idx; s.e = r.o; s.m = '1;
    if (r.pcx) s.m.pc = '0;
    sb_q.push_back(s);
  endtask

  task automatic test_reset;
    row_t t[5];
    sb_t  s;
    t[0] = rw(1, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h0, 16'h0, 1);
    t[1] = rw(1, 1, 1, 1, 32'h42, 9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h0, 16'h0, 1);
    t[2] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    t[3] = rw(0, 0, 0, 0, 32'h0,  9'h010, 1, 0, 1, 0, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    t[4] = rw(0, 0, 0, 0, 32'h0,  9'h1FC, 0, 0, 0, 1, 9'h000, 0, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(t[i], "reset_seq", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect;
    row_t t[2];
    sb_t  s;
    t[0] = rw(0, 1, 1, 1, 32'h40, 9'h010, 1, 0, 1, 1, 9'h040, 1, 0, 0, 16'h0, 16'h0, 0);
    t[1] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h1, 16'h1, 0);
    for (int i = 0; i < 2; i++) begin
      apply(t[i], "redirect", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold;
    row_t t[6];
    sb_t  s;
    t[0] = rw(0, 1, 1, 1, 32'h40, 9'h010, 0, 0, 0, 1, 9'h040, 1, 0, 0, 16'h1, 16'h1, 0);
    t[1] = rw(0, 1, 1, 1, 32'h80, 9'h010, 1, 0, 0, 1, 9'h040, 1, 0, 0, 16'h2, 16'h1, 0);
    t[2] = rw(0, 1, 1, 1, 32'h80, 9'h020, 1, 0, 0, 1, 9'h040, 1, 0, 0, 16'h2, 16'h1, 0);
    t[3] = rw(0, 1, 1, 1, 32'h44, 9'h020, 0, 0, 0, 1, 9'h040, 1, 0, 0, 16'h2, 16'h1, 0);
    t[4] = rw(0, 1, 1, 1, 32'h80, 9'h020, 1, 0, 1, 1, 9'h040, 1, 0, 0, 16'h2, 16'h1, 0);
    t[5] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h2, 16'h2, 0);
    for (int i = 0; i < 6; i++) begin
      apply(t[i], "hold", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_misalign;
    row_t t[5];
    sb_t  s;
    t[0] = rw(0, 1, 0, 1, 32'h42, 9'h010, 0, 0, 1, 1, 9'h000, 1, 1, 0, 16'h2, 16'h2, 0);
    t[1] = rw(0, 0, 1, 1, 32'h40, 9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h2, 16'h3, 0);
    t[2] = rw(0, 1, 0, 1, 32'h46, 9'h010, 0, 0, 0, 1, 9'h000, 1, 1, 0, 16'h2, 16'h3, 0);
    t[3] = rw(0, 1, 0, 1, 32'h46, 9'h010, 0, 0, 1, 1, 9'h000, 1, 0, 0, 16'h2, 16'h3, 0);
    t[4] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h2, 16'h4, 0);
    for (int i = 0; i < 5; i++) begin
      apply(t[i], "misalign", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt;
    row_t t[11];
    sb_t  s;
    t[0]  = rw(0, 1, 0, 1, 32'h40, 9'h010, 0, 0, 0, 1, 9'h040, 1, 0, 0, 16'h2, 16'h4, 0);
    t[1]  = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 1, 0, 1, 9'h040, 1, 0, 0, 16'h2, 16'h4, 0);
    t[2]  = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 1, 1, 1, 9'h040, 1, 0, 0, 16'h2, 16'h4, 0);
    t[3]  = rw(0, 1, 1, 1, 32'h40, 9'h010, 0, 0, 1, 0, 9'h000, 0, 0, 1, 16'h2, 16'h5, 1);
    t[4]  = rw(0, 1, 1, 1, 32'h40, 9'h010, 0, 0, 1, 0, 9'h000, 0, 0, 1, 16'h2, 16'h5, 1);
    t[5]  = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 0, 0, 1, 16'h2, 16'h5, 1);
    t[6]  = rw(1, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h2, 16'h5, 1);
    t[7]  = rw(1, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h0, 16'h0, 1);
    t[8]  = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    t[9]  = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 1, 1, 0, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    t[10] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 0, 0, 1, 16'h0, 16'h0, 1);
    for (int i = 0; i < 11; i++) begin
      apply(t[i], "halt", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_hold;
    row_t t[4];
    sb_t  s;
    t[0] = rw(1, 0, 0, 0, 32'h0,  9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h0, 16'h0, 1);
    t[1] = rw(0, 1, 1, 1, 32'h40, 9'h010, 0, 0, 0, 1, 9'h040, 1, 0, 0, 16'h0, 16'h0, 0);
    t[2] = rw(1, 0, 0, 0, 32'h0,  9'h010, 0, 0, 0, 0, 9'h000, 1, 0, 0, 16'h1, 16'h0, 1);
    t[3] = rw(0, 0, 0, 0, 32'h0,  9'h010, 0, 0, 0, 1, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(t[i], "reset_in_hold", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation;
    row_t t[5];
    row_t fill;
    sb_t  s;
    apply(rw(1, 0, 0, 0, 32'h0, 9'h010, 0, 0, 1, 0, 9'h000, 1, 0, 0, 16'h0, 16'h0, 1), "sat_reset", 0);
    void'(sb_q.pop_front());
    @(posedge clk); #1;
    fill = rw(0, 1, 1, 0, 32'h0, 9'h010, 0, 0, 1, 1, 9'h014, 0, 0, 0, 16'h0, 16'h0, 0);
    reset = fill.rst; ex_valid = fill.v; ex_ctrl = fill.c; ex_pcsel = fill.p; pc_ready = fill.ready;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    t[0] = rw(0, 0, 0, 0, 32'h0, 9'h1FC, 0, 0, 1, 1, 9'h000, 0, 0, 0, 16'hFFFE, 16'h0, 0);
    t[1] = rw(0, 1, 1, 0, 32'h0, 9'h1FC, 0, 0, 1, 1, 9'h000, 0, 0, 0, 16'hFFFE, 16'h0, 0);
    t[2] = rw(0, 1, 1, 0, 32'h0, 9'h1FC, 0, 0, 1, 1, 9'h000, 0, 0, 0, 16'hFFFF, 16'h0, 0);
    t[3] = rw(0, 1, 1, 0, 32'h0, 9'h1FC, 0, 0, 1, 1, 9'h000, 0, 0, 0, 16'hFFFF, 16'h0, 0);
    t[4] = rw(0, 0, 0, 0, 32'h0, 9'h1FC, 0, 0, 1, 1, 9'h000, 0, 0, 0, 16'hFFFF, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(t[i], "saturation", i);
      @(negedge clk);
      s = sb_q.pop_front();
      checks++;
      if ((obs & s.m) !== (s.e & s.m)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", s.name, s.idx, obs & s.m, s.e & s.m);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_redirect;
    test_hold;
    test_misalign;
    test_halt;
    test_reset_in_hold;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
